// File: rtl/adc_pack_pkg.sv
// Shared helpers for the ADC channel packer: popcount, slot index sizing and mask typedef.
package adc_pack_pkg;

    localparam int MAX_CH     = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int SLOT_IDX_W = $clog2(2 * DEF_NUM_CH);

    typedef logic [MAX_CH-1:0] ch_mask_t;

    function automatic int slot_idx_w(input int num_ch);
        return $clog2(2 * num_ch);
    endfunction

    function automatic logic [3:0] popcount(input ch_mask_t m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + {3'd0, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/adc_pack_compact.sv
// Compacts the samples of enabled lanes into the low slots (ascending lane order)
// and reports how many lanes are enabled.
module adc_pack_compact
    import adc_pack_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 16,
    parameter int KW     = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]      en,
    input  logic [NUM_CH*CH_W-1:0] data,
    output logic [NUM_CH*CH_W-1:0] slots,
    output logic [KW-1:0]          k
);

    ch_mask_t   full_m;
    ch_mask_t   below_m;
    logic [3:0] rank;

    // Each enabled lane lands in the slot equal to the number of enabled lanes below it.
    always_comb begin
        full_m             = '0;
        full_m[NUM_CH-1:0] = en;
        k                  = KW'(popcount(full_m));
        slots              = '0;
        below_m            = '0;
        rank               = 4'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            below_m = '0;
            for (int b = 0; b < c; b++) begin
                below_m[b] = en[b];
            end
            rank = popcount(below_m);
            for (int s = 0; s < NUM_CH; s++) begin
                if (en[c] && (rank == 4'(s))) begin
                    slots[s*CH_W +: CH_W] = data[c*CH_W +: CH_W];
                end else begin
                    slots[s*CH_W +: CH_W] = slots[s*CH_W +: CH_W];
                end
            end
        end
    end

endmodule

// File: rtl/adc_chan_pack.sv
// Packs samples of enabled ADC lanes into dense NUM_CH-slot words for the DMA.
// Optional ADC_PACK_STATUS_EN builds the saturating discarded-partial-word counter.
module adc_chan_pack
    import adc_pack_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 16
) (
    input  logic                   adc_clk,
    input  logic                   adc_rst,
    input  logic [NUM_CH-1:0]      adc_enable,
    input  logic                   adc_valid,
    input  logic [NUM_CH*CH_W-1:0] adc_data,
    output logic                   pack_valid,
    output logic [NUM_CH*CH_W-1:0] pack_data,
    output logic                   pack_sync,
    output logic                   pack_ovf,
    output logic [15:0]            pack_discards
);

    localparam int FW = slot_idx_w(NUM_CH);
    localparam int KW = $clog2(NUM_CH + 1);
    localparam int NS = 2 * NUM_CH;
    localparam int W  = NUM_CH * CH_W;

    logic [NS-1:0][CH_W-1:0] buf_q, buf_d, buf_app_s;
    logic [FW-1:0]           fill_q, fill_d, base_s, total_s;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic                    sync_pend_q, sync_pend_d;
    logic                    pack_valid_q, pack_valid_d;
    logic [W-1:0]            pack_data_q, pack_data_d;
    logic                    pack_sync_q, pack_sync_d;
    logic                    pack_ovf_q, pack_ovf_d;
    logic [W-1:0]            comp_s;
    logic [KW-1:0]           k_s;
    logic                    mask_chg_s, emit_s;

    adc_pack_compact #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .KW     (KW)
    ) u_compact (
        .en    (adc_enable),
        .data  (adc_data),
        .slots (comp_s),
        .k     (k_s)
    );

    // Append, emit/shift and mask-change handling.
    always_comb begin
        mask_d     = adc_enable;
        mask_chg_s = (adc_enable != mask_q);
        base_s     = mask_chg_s ? '0 : fill_q;
        total_s    = base_s + FW'(k_s);
        buf_app_s  = buf_q;
        if (adc_valid) begin
            for (int i = 0; i < NS; i++) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    if ((j < int'(k_s)) && ((int'(base_s) + j) == i)) begin
                        buf_app_s[i] = comp_s[j*CH_W +: CH_W];
                    end else begin
                        buf_app_s[i] = buf_app_s[i];
                    end
                end
            end
        end else begin
            buf_app_s = buf_q;
        end

        emit_s = adc_valid && (int'(total_s) >= NUM_CH);
        buf_d  = buf_app_s;
        if (emit_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                buf_d[i]          = buf_app_s[i+NUM_CH];
                buf_d[i+NUM_CH]   = '0;
            end
            fill_d      = total_s - FW'(NUM_CH);
            pack_data_d = buf_app_s[NUM_CH-1:0];
        end else if (adc_valid) begin
            fill_d      = total_s;
            pack_data_d = pack_data_q;
        end else begin
            fill_d      = base_s;
            pack_data_d = pack_data_q;
        end

        pack_valid_d = emit_s;
        pack_sync_d  = emit_s && (sync_pend_q || mask_chg_s);
        sync_pend_d  = emit_s ? 1'b0 : (sync_pend_q || mask_chg_s);
        // A mask change only counts as a discard when a partial word was pending.
        pack_ovf_d   = mask_chg_s && (fill_q != '0);
    end

    // State and output registers.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            buf_q        <= '0;
            fill_q       <= '0;
            mask_q       <= '0;
            sync_pend_q  <= 1'b1;
            pack_valid_q <= 1'b0;
            pack_data_q  <= '0;
            pack_sync_q  <= 1'b0;
            pack_ovf_q   <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            mask_q       <= mask_d;
            sync_pend_q  <= sync_pend_d;
            pack_valid_q <= pack_valid_d;
            pack_data_q  <= pack_data_d;
            pack_sync_q  <= pack_sync_d;
            pack_ovf_q   <= pack_ovf_d;
        end
    end

    assign pack_valid = pack_valid_q;
    assign pack_data  = pack_data_q;
    assign pack_sync  = pack_sync_q;
    assign pack_ovf   = pack_ovf_q;

`ifdef ADC_PACK_STATUS_EN
    logic [15:0] discards_q, discards_d;

    // Saturating count of discarded partial words.
    always_comb begin
        if (pack_ovf_d && (discards_q != 16'hFFFF)) begin
            discards_d = discards_q + 16'd1;
        end else begin
            discards_d = discards_q;
        end
    end

    // Discard counter register, cleared only by reset.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            discards_q <= 16'd0;
        end else begin
            discards_q <= discards_d;
        end
    end

    assign pack_discards = discards_q;
`else
    assign pack_discards = 16'd0;
`endif

endmodule
